// File: rtl/mini_cpu_pkg.sv
// Shared opcodes, FSM state encoding and the ALU helper for the mini CPU core.
// Define MINI_CPU_SAT_EN to clamp overflowing results instead of wrapping them.
package mini_cpu_pkg;

  localparam logic [2:0] OP_LOAD    = 3'd0;
  localparam logic [2:0] OP_ADD     = 3'd1;
  localparam logic [2:0] OP_ADDI    = 3'd2;
  localparam logic [2:0] OP_SUB     = 3'd3;
  localparam logic [2:0] OP_SUBI    = 3'd4;
  localparam logic [2:0] OP_MUL     = 3'd5;
  localparam logic [2:0] OP_CLEAR   = 3'd6;
  localparam logic [2:0] OP_DISPLAY = 3'd7;

  // Widest datapath the ALU helper supports; narrower cores zero-extend into it.
  localparam int MAX_W = 32;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_READ1, S_READ2, S_EXEC, S_WRITE, S_CLEAR, S_SHOW
  } state_t;

  typedef logic [MAX_W-1:0]   alu_word_t;
  typedef logic [2*MAX_W-1:0] alu_wide_t;

  // Returns {ovf, result}; result is already reduced to 'width' bits.
  function automatic logic [MAX_W:0] alu_exec(input logic [2:0] op,
                                              input alu_word_t a,
                                              input alu_word_t b,
                                              input int width);
    alu_wide_t full;
    alu_wide_t mask;
    logic      ovf;
    alu_word_t res;
    mask = (alu_wide_t'(1) << width) - alu_wide_t'(1);
    full = '0;
    ovf  = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        full = alu_wide_t'(a) + alu_wide_t'(b);
        ovf  = |(full >> width);
      end
      OP_SUB, OP_SUBI: begin
        full = alu_wide_t'(a) - alu_wide_t'(b);
        ovf  = (a < b);
      end
      OP_MUL: begin
        full = alu_wide_t'(a) * alu_wide_t'(b);
        ovf  = |(full >> width);
      end
      default: begin
        full = '0;
        ovf  = 1'b0;
      end
    endcase
    res = alu_word_t'(full & mask);
`ifdef MINI_CPU_SAT_EN
    if (ovf) res = ((op == OP_SUB) || (op == OP_SUBI)) ? '0 : alu_word_t'(mask);
`endif
    return {ovf, res};
  endfunction

endpackage

// File: rtl/mini_cpu_if.sv
// Instruction and display handshake bundle between the front end, the core and the LCD driver.
interface mini_cpu_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int IMM_W = 7
);
  localparam int AW = $clog2(DEPTH);

  logic             instr_valid;
  logic             instr_ready;
  logic [2:0]       instr_op;
  logic [AW-1:0]    instr_dst;
  logic [AW-1:0]    instr_src1;
  logic [AW-1:0]    instr_src2;
  logic [IMM_W-1:0] instr_imm;
  logic             disp_valid;
  logic             disp_ready;
  logic [2:0]       disp_op;
  logic [AW-1:0]    disp_addr;
  logic [WIDTH-1:0] disp_data;

  modport master (
    output instr_valid, instr_op, instr_dst, instr_src1, instr_src2, instr_imm, disp_ready,
    input  instr_ready, disp_valid, disp_op, disp_addr, disp_data
  );

  modport slave (
    input  instr_valid, instr_op, instr_dst, instr_src1, instr_src2, instr_imm, disp_ready,
    output instr_ready, disp_valid, disp_op, disp_addr, disp_data
  );
endinterface

// File: rtl/mini_cpu_regfile.sv
// DEPTH x WIDTH register file: one synchronous write port, one registered read port, no reset.
module mini_cpu_regfile #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mini_cpu_core.sv
// Instruction-driven mini CPU core: multi-cycle FSM over a register file with a display handshake.
// Build option MINI_CPU_SAT_EN makes overflowing results saturate instead of wrap.
module mini_cpu_core
  import mini_cpu_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  parameter  int IMM_W = 7,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  mini_cpu_if.slave        bus,
  output logic             busy,
  output logic             flag_ovf,
  output logic [WIDTH-1:0] last_result
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t           state, next_state;
  logic [AW-1:0]    sweep_cnt;
  logic [2:0]       op_q;
  logic [AW-1:0]    dst_q, src1_q, src2_q;
  logic [IMM_W-1:0] imm_q;
  logic [WIDTH-1:0] op_a_q, result_q;

  logic             rf_we;
  logic [AW-1:0]    rf_waddr, rf_raddr;
  logic [WIDTH-1:0] rf_wdata, rf_rdata;

  logic             accept, two_src, sweep_done, alu_ovf;
  logic [WIDTH-1:0] imm_ext, alu_a, alu_b, alu_res, wr_value;
  logic [MAX_W:0]   alu_out;

  assign accept     = bus.instr_valid && (state == S_IDLE);
  assign two_src    = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign sweep_done = (sweep_cnt == LAST_ADDR);
  assign imm_ext    = WIDTH'(imm_q);

  // For two-source ops the first operand was parked in READ2; the regfile now holds src2.
  assign alu_a    = two_src ? op_a_q : rf_rdata;
  assign alu_b    = two_src ? rf_rdata : imm_ext;
  assign alu_out  = alu_exec(op_q, alu_word_t'(alu_a), alu_word_t'(alu_b), WIDTH);
  assign alu_ovf  = alu_out[MAX_W];
  assign alu_res  = WIDTH'(alu_out[MAX_W-1:0]);
  assign wr_value = (op_q == OP_LOAD) ? imm_ext : result_q;

  mini_cpu_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_regfile (
    .clk   (clk),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_INIT:  if (sweep_done) next_state = S_IDLE;
      S_IDLE: begin
        if (bus.instr_valid) begin
          case (bus.instr_op)
            OP_LOAD:  next_state = S_WRITE;
            OP_CLEAR: next_state = S_CLEAR;
            default:  next_state = S_READ1;
          endcase
        end
      end
      S_READ1: begin
        if (op_q == OP_DISPLAY) next_state = S_SHOW;
        else if (two_src)       next_state = S_READ2;
        else                    next_state = S_EXEC;
      end
      S_READ2: next_state = S_EXEC;
      S_EXEC:  next_state = S_WRITE;
      S_WRITE: next_state = S_SHOW;
      S_CLEAR: if (sweep_done) next_state = S_SHOW;
      S_SHOW:  if (bus.disp_ready) next_state = S_IDLE;
      default: next_state = S_INIT;
    endcase
  end

  // Display fields are forced to zero outside SHOW so reset and idle present a clean bus.
  always_comb begin
    bus.instr_ready = 1'b0;
    bus.disp_valid  = 1'b0;
    bus.disp_op     = 3'd0;
    bus.disp_addr   = '0;
    bus.disp_data   = '0;
    busy            = rst_n && (state != S_IDLE);
    rf_we           = 1'b0;
    rf_waddr        = sweep_cnt;
    rf_wdata        = '0;
    rf_raddr        = (state == S_READ2) ? src2_q : src1_q;
    case (state)
      S_INIT, S_CLEAR: rf_we = 1'b1;
      S_IDLE:          bus.instr_ready = 1'b1;
      S_WRITE: begin
        rf_we    = 1'b1;
        rf_waddr = dst_q;
        rf_wdata = wr_value;
      end
      S_SHOW: begin
        bus.disp_valid = 1'b1;
        bus.disp_op    = op_q;
        if (op_q == OP_DISPLAY) begin
          bus.disp_addr = src1_q;
          bus.disp_data = rf_rdata;
        end else begin
          bus.disp_addr = dst_q;
          bus.disp_data = result_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt   <= '0;
      op_q        <= 3'd0;
      dst_q       <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      imm_q       <= '0;
      op_a_q      <= '0;
      result_q    <= '0;
      flag_ovf    <= 1'b0;
      last_result <= '0;
    end else begin
      if ((state == S_INIT) || (state == S_CLEAR)) sweep_cnt <= sweep_cnt + 1'b1;
      if (accept) begin
        op_q   <= bus.instr_op;
        dst_q  <= bus.instr_dst;
        src1_q <= bus.instr_src1;
        src2_q <= bus.instr_src2;
        imm_q  <= bus.instr_imm;
        if ((bus.instr_op == OP_LOAD) || (bus.instr_op == OP_CLEAR)) flag_ovf <= 1'b0;
        if (bus.instr_op == OP_CLEAR) begin
          last_result <= '0;
          result_q    <= '0;
        end
      end
      if (state == S_READ2) op_a_q <= rf_rdata;
      if (state == S_EXEC) begin
        result_q <= alu_res;
        flag_ovf <= alu_ovf;
      end
      if (state == S_WRITE) begin
        result_q    <= wr_value;
        last_result <= wr_value;
      end
    end
  end

endmodule

// File: tb/tb_mini_cpu_core.sv
// Randomized self-checking bench for mini_cpu_core against a behavioural register-file model.
module tb_mini_cpu_core;
  import mini_cpu_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int IMM_W = 7;
  localparam int AW    = $clog2(DEPTH);
  localparam int unsigned MAXV = 65535;
`ifdef MINI_CPU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             busy, flag_ovf;
  logic [WIDTH-1:0] last_result;
  logic [WIDTH-1:0] shown;

  int checks   = 0;
  int failures = 0;

  int unsigned model_regs [DEPTH];
  int unsigned model_flag;
  int unsigned model_last;

  mini_cpu_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IMM_W(IMM_W)) cpu_bus ();

  mini_cpu_core #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IMM_W(IMM_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (cpu_bus),
    .busy        (busy),
    .flag_ovf    (flag_ovf),
    .last_result (last_result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural effect of one instruction computed from plain arithmetic on the model state.
  task automatic modelExecute(input logic [2:0] op, input int dst, input int s1, input int s2,
                              input int imm, output int lat, output int addr,
                              output int unsigned data);
    longint unsigned a, b, r;
    bit ovf;
    a = model_regs[s1];
    b = ((op == OP_ADD) || (op == OP_SUB)) ? longint'(model_regs[s2]) : longint'(imm);
    lat  = ((op == OP_ADD) || (op == OP_SUB)) ? 5 : 4;
    addr = dst;
    ovf  = 1'b0;
    r    = 0;
    case (op)
      OP_LOAD: begin
        r = imm; lat = 2; model_flag = 0;
      end
      OP_ADD, OP_ADDI: begin
        r = a + b; ovf = (r > MAXV);
        if (ovf) r = SAT ? MAXV : r - 65536;
      end
      OP_SUB, OP_SUBI: begin
        ovf = (a < b);
        r   = ovf ? (SAT ? 0 : a + 65536 - b) : a - b;
      end
      OP_MUL: begin
        r = a * b; ovf = (r > MAXV);
        if (ovf) r = SAT ? MAXV : r % 65536;
      end
      OP_CLEAR: begin
        for (int i = 0; i < DEPTH; i++) model_regs[i] = 0;
        lat = DEPTH + 1; model_flag = 0; model_last = 0;
      end
      default: begin
        lat = 2; addr = s1; r = a;
      end
    endcase
    if ((op != OP_CLEAR) && (op != OP_DISPLAY)) begin
      model_regs[dst] = int'(r);
      model_last      = int'(r);
      if (op != OP_LOAD) model_flag = ovf;
    end
    data = (op == OP_CLEAR) ? 0 : int'(r);
  endtask

  // Issues one instruction, checks latency and the display record, stalls SHOW, then releases it.
  task automatic applyStimulus(input logic [2:0] op, input int dst, input int s1, input int s2,
                               input int imm, input int stall, output logic [WIDTH-1:0] seen);
    int n, lat, exp_lat, exp_addr;
    int unsigned exp_data;
    seen = '0;
    n = 0;
    @(negedge clk);
    while (!cpu_bus.instr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_bus.instr_ready) begin
      checkOutput("ready_timeout", 0, 1);
      return;
    end
    cpu_bus.instr_op    = op;
    cpu_bus.instr_dst   = AW'(dst);
    cpu_bus.instr_src1  = AW'(s1);
    cpu_bus.instr_src2  = AW'(s2);
    cpu_bus.instr_imm   = IMM_W'(imm);
    cpu_bus.instr_valid = 1'b1;
    cpu_bus.disp_ready  = 1'b0;
    modelExecute(op, dst, s1, s2, imm, exp_lat, exp_addr, exp_data);
    @(posedge clk);
    #1;
    cpu_bus.instr_valid = 1'b0;
    cpu_bus.instr_op    = 3'($urandom);
    cpu_bus.instr_dst   = AW'($urandom);
    cpu_bus.instr_src1  = AW'($urandom);
    cpu_bus.instr_src2  = AW'($urandom);
    cpu_bus.instr_imm   = IMM_W'($urandom);
    @(negedge clk);
    lat = 1;
    while (!cpu_bus.disp_valid && lat < DEPTH + 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", lat, exp_lat);
    if (!cpu_bus.disp_valid) return;
    seen = cpu_bus.disp_data;
    checkOutput("disp_op", cpu_bus.disp_op, op);
    checkOutput("disp_addr", cpu_bus.disp_addr, exp_addr);
    checkOutput("disp_data", cpu_bus.disp_data, exp_data);
    checkOutput("flag_ovf", flag_ovf, model_flag);
    checkOutput("last_result", last_result, model_last);
    checkOutput("busy_show", busy, 1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", cpu_bus.disp_valid, 1);
      checkOutput("stall_data", cpu_bus.disp_data, exp_data);
      checkOutput("stall_ready", cpu_bus.instr_ready, 0);
    end
    cpu_bus.disp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_bus.disp_ready = 1'b0;
    checkOutput("idle_after_show", cpu_bus.instr_ready, 1);
    checkOutput("valid_drop", cpu_bus.disp_valid, 0);
  endtask

  // Asserts reset at the current time, checks the quiet outputs, then times the clearing sweep.
  task automatic resetAndInit();
    int n;
    bit saw_disp;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", cpu_bus.instr_ready, 0);
    checkOutput("rst_valid", cpu_bus.disp_valid, 0);
    checkOutput("rst_flag", flag_ovf, 0);
    checkOutput("rst_last", last_result, 0);
    checkOutput("rst_data", cpu_bus.disp_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    saw_disp = 1'b0;
    while (!cpu_bus.instr_ready && n < 100) begin
      if (cpu_bus.disp_valid) saw_disp = 1'b1;
      n++;
      @(negedge clk);
    end
    checkOutput("init_cycles", n, DEPTH);
    checkOutput("init_no_disp", saw_disp, 0);
    for (int i = 0; i < DEPTH; i++) model_regs[i] = 0;
    model_flag = 0;
    model_last = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int op, n;
    cpu_bus.instr_valid = 1'b0;
    cpu_bus.instr_op    = 3'd0;
    cpu_bus.instr_dst   = '0;
    cpu_bus.instr_src1  = '0;
    cpu_bus.instr_src2  = '0;
    cpu_bus.instr_imm   = '0;
    cpu_bus.disp_ready  = 1'b0;
    #2;
    resetAndInit();

    applyStimulus(OP_DISPLAY, 0, 5, 0, 0, 0, shown);
    checkOutput("display_zero", shown, 16'h0000);

    applyStimulus(OP_LOAD, 2, 0, 0, 100, 0, shown);
    applyStimulus(OP_LOAD, 3, 0, 0, 27, 0, shown);
    applyStimulus(OP_ADD, 4, 2, 3, 0, 0, shown);
    checkOutput("add_127", shown, 127);
    checkOutput("add_flag", flag_ovf, 0);

    applyStimulus(OP_LOAD, 1, 0, 0, 127, 0, shown);
    applyStimulus(OP_ADDI, 1, 1, 0, 127, 0, shown);
    applyStimulus(OP_ADDI, 1, 1, 0, 1, 0, shown);
    applyStimulus(OP_ADDI, 7, 1, 0, 0, 0, shown);
    applyStimulus(OP_MUL, 1, 1, 0, 16, 0, shown);
    applyStimulus(OP_MUL, 1, 1, 0, 16, 0, shown);
    applyStimulus(OP_ADD, 1, 1, 7, 0, 0, shown);
    checkOutput("r1_ffff", shown, 16'hFFFF);
    applyStimulus(OP_ADDI, 1, 1, 0, 1, 0, shown);
    checkOutput("addi_wrap", shown, SAT ? 16'hFFFF : 16'h0000);
    checkOutput("addi_flag", flag_ovf, 1);

    applyStimulus(OP_SUB, 6, 3, 2, 0, 0, shown);
    checkOutput("sub_borrow", shown, SAT ? 16'h0000 : 16'hFFB7);
    checkOutput("sub_flag", flag_ovf, 1);

    applyStimulus(OP_LOAD, 9, 0, 0, 55, 10, shown);
    applyStimulus(OP_CLEAR, 5, 0, 0, 0, 2, shown);

    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 7));
      if ((op == int'(OP_CLEAR)) && ($urandom_range(0, 3) != 0)) op = int'(OP_LOAD);
      applyStimulus(3'(op), int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                    int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 3)), shown);
    end

    applyStimulus(OP_LOAD, 2, 0, 0, 99, 0, shown);
    n = 0;
    @(negedge clk);
    while (!cpu_bus.instr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mul_ready", cpu_bus.instr_ready, 1);
    cpu_bus.instr_op    = OP_MUL;
    cpu_bus.instr_dst   = AW'(1);
    cpu_bus.instr_src1  = AW'(2);
    cpu_bus.instr_src2  = AW'(0);
    cpu_bus.instr_imm   = IMM_W'(3);
    cpu_bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    cpu_bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("busy_in_exec", busy, 1);
    resetAndInit();
    for (int r = 0; r < DEPTH; r++) begin
      applyStimulus(OP_DISPLAY, 0, r, 0, 0, 0, shown);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mini_cpu_core.md
Name: mini_cpu_core

Overview:
- Parametrised successor to the switch-driven mini CPU controller: an instruction-driven core with a register file, ALU and display handshake.
- Accepts one instruction per valid/ready handshake and executes it over a multi-cycle FSM:
  - reads operands from an internal DEPTH x WIDTH register file;
  - computes LOAD/ADD/ADDI/SUB/SUBI/MUL/CLEAR/DISPLAY;
  - writes the result back;
  - presents the destination value to the LCD driver through a valid/ready display port.
- Sits between the front-end instruction source (switch decoder or sequencer) and lcd_display.

Parameters:
- WIDTH, 16, data/register width in bits (>=8).
- DEPTH, 16, number of registers (power of two, >=2).
- AW, $clog2(DEPTH), register address width (derived, not overridden).
- IMM_W, 7, immediate width; zero-extended to WIDTH (IMM_W <= WIDTH).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  core can accept an instruction
- instr_op  in  3  opcode: 0 LOAD, 1 ADD, 2 ADDI, 3 SUB, 4 SUBI, 5 MUL, 6 CLEAR, 7 DISPLAY
- instr_dst  in  AW  destination register
- instr_src1  in  AW  first source register
- instr_src2  in  AW  second source register (ADD/SUB only)
- instr_imm  in  IMM_W  immediate (LOAD/ADDI/SUBI/MUL)
- disp_valid  out  1  display record valid
- disp_ready  in  1  LCD driver accepts record
- disp_op  out  3  opcode of the completed instruction
- disp_addr  out  AW  register shown
- disp_data  out  WIDTH  value of the shown register
- busy  out  1  high whenever FSM is not in IDLE
- flag_ovf  out  1  overflow/borrow flag of the last arithmetic op
- last_result  out  WIDTH  last value written by an arithmetic or LOAD op

Behaviour:
- Reset (async assert, sync release). All outputs 0; FSM enters INIT. INIT sweeps addresses 0..DEPTH-1, writing 0, one per cycle: busy=1, instr_ready=0 for exactly DEPTH cycles, then IDLE. Reset asserted mid-operation aborts immediately; no disp_valid is issued for the aborted instruction.
- Handshake. instr_ready=1 only in IDLE. Instruction fields are captured on the edge where instr_valid&&instr_ready. Fields need not be held afterwards.
- Register file: synchronous write; synchronous read with 1-cycle latency.
- FSM states: INIT, IDLE, READ1, READ2, EXEC, WRITE, CLEAR, SHOW.
- Paths and latency (accept edge = cycle 0, number = cycle disp_valid rises):
  - LOAD: IDLE->WRITE->SHOW (2). Writes zero-extended imm.
  - ADDI, SUBI, MUL: IDLE->READ1->EXEC->WRITE->SHOW (4). Operand b = zext(imm).
  - ADD, SUB: IDLE->READ1->READ2->EXEC->WRITE->SHOW (5). Operand b = R[src2].
  - CLEAR: IDLE->CLEAR (DEPTH cycles, addresses ascending)->SHOW (DEPTH+1). disp_addr=dst, disp_data=0.
  - DISPLAY: IDLE->READ1->SHOW (2). disp_addr=src1, disp_data=R[src1]; no write.
- src1==src2 or dst==src is legal. Operands are captured before the write, so the result always uses pre-instruction values.
- SHOW. disp_valid=1 with disp_op/addr/data stable until disp_ready is high on a rising edge, then IDLE the next cycle. disp_data after WRITE is the just-written value. disp_ready low indefinitely stalls the core.
- Arithmetic, WIDTH bits, unsigned, results modulo 2^WIDTH:
  - flag_ovf = carry-out for ADD/ADDI;
  - flag_ovf = borrow (a<b) for SUB/SUBI;
  - flag_ovf = any nonzero bit above WIDTH of the 2*WIDTH product for MUL.
- flag_ovf updates in EXEC. LOAD and CLEAR clear it; DISPLAY preserves it.
- last_result updates on the WRITE of LOAD and arithmetic ops; CLEAR sets it to 0.

Optional Feature:
- Macro MINI_CPU_SAT_EN.
- Defined: on overflow, results clamp instead of wrapping.
  - ADD/ADDI/MUL -> all ones.
  - SUB/SUBI -> 0.
  - flag_ovf still reports that the clamp occurred.
- Undefined: modulo wrap as above; no clamp logic is synthesised.

Decomposition:
- Package mini_cpu_pkg holds:
  - opcode localparams (OP_LOAD..OP_DISPLAY);
  - FSM state encoding;
  - a function returning {ovf, result} for op/a/b/WIDTH.
- One sub-module, mini_cpu_regfile: DEPTH x WIDTH, one write port, one sync read port, no reset. The core owns clearing via INIT/CLEAR.

Test Plan (WIDTH=16, DEPTH=16, IMM_W=7):
- Release rst_n -> instr_ready stays 0 for 16 cycles. Then DISPLAY src1=5 -> disp_data=0x0000, disp_valid at cycle 2.
- LOAD dst=2 imm=100, LOAD dst=3 imm=27, ADD dst=4 src1=2 src2=3 -> disp_addr=4, disp_data=127, disp_valid at cycle 5, flag_ovf=0.
- R1=0xFFFF (built with LOAD 127 and MUL chain), ADDI dst=1 src1=1 imm=1 -> result 0x0000, flag_ovf=1. With MINI_CPU_SAT_EN -> 0xFFFF, flag_ovf=1.
- SUB dst=6 src1=3(27) src2=2(100) -> 0xFFB7, flag_ovf=1. With SAT_EN -> 0x0000.
- Hold disp_ready=0 for 10 cycles during SHOW -> disp_valid and disp_data stable, instr_ready=0. Assert disp_ready -> IDLE next cycle.
- Pulse rst_n low during EXEC of MUL -> outputs 0 immediately, no disp_valid, INIT sweep runs, every register reads 0.
